axi_rr_arbiter: RTL and testbench
=================================

Name: axi_rr_arbiter

Overview:
- N-input to 1-output AXI-Lite arbiter with round-robin fairness.
- Shares a single AXI-Lite slave, typically axi_sram_controller, between several masters.
- Write and read paths are arbitrated independently, so one master's write can overlap another master's read.
- Each grant is held for a full transaction: address, then data, then response.

Parameters:
- NUM_IN, 3, number of requesting masters (2..8).
- AXI_ADDR_WIDTH, 20, address width.
- AXI_DATA_WIDTH, 16, data width.
- AXI_STRB_WIDTH, (AXI_DATA_WIDTH+7)/8, strobe width (derived).

Ports:
- Clocking:
  - axi_clk  in  1  clock.
  - axi_reset  in  1  synchronous, active-high reset.
- Input side: bus ports are packed, with slice i belonging to master i; 1-bit-per-master ports use bit i.
  - in_axi_awaddr  in  NUM_IN*AXI_ADDR_WIDTH  write addresses.
  - in_axi_awvalid / in_axi_awready  in / out  NUM_IN  AW handshake.
  - in_axi_wdata  in  NUM_IN*AXI_DATA_WIDTH  write data.
  - in_axi_wstrb  in  NUM_IN*AXI_STRB_WIDTH  write strobes.
  - in_axi_wvalid / in_axi_wready  in / out  NUM_IN  W handshake.
  - in_axi_bresp  out  NUM_IN*2  write responses.
  - in_axi_bvalid / in_axi_bready  out / in  NUM_IN  B handshake.
  - in_axi_araddr  in  NUM_IN*AXI_ADDR_WIDTH  read addresses.
  - in_axi_arvalid / in_axi_arready  in / out  NUM_IN  AR handshake.
  - in_axi_rdata  out  NUM_IN*AXI_DATA_WIDTH  read data.
  - in_axi_rresp  out  NUM_IN*2  read responses.
  - in_axi_rvalid / in_axi_rready  out / in  NUM_IN  R handshake.
- Output side:
  - out_axi_aw*, out_axi_w*, out_axi_b*, out_axi_ar*, out_axi_r*  mirror directions  single-master widths  AXI-Lite master port to the shared slave.

Behaviour:
- Two independent FSMs, write (WR) and read (RD), each with states IDLE -> ADDR -> RESP -> IDLE.
- Each FSM has a registered grant index (clog2(NUM_IN) bits) and a last-grant pointer.
- Reset:
  - Both FSMs go to IDLE.
  - Both last-grant pointers = NUM_IN-1, so master 0 wins first.
  - All out_*valid, out_bready, out_rready = 0.
  - All in_*ready, in_bvalid, in_rvalid = 0.
  - Data and address outputs = 0.
  - Reset mid-transaction drops the transaction silently; no response is forwarded.
- WR IDLE:
  - If any in_awvalid is set, choose the first requester scanning from last_wr+1 upward, modulo NUM_IN.
  - Register it as wr_grant, clear aw_done/w_done, and go to ADDR.
  - in_axi_wvalid alone never triggers a grant.
- WR ADDR:
  - out_aw*, out_w* and out_bready are driven combinationally from master wr_grant.
  - in_awready[g] = out_awready while !aw_done; in_wready[g] = out_wready while !w_done.
  - After a handshake, aw_done/w_done sets and the matching out valid is forced to 0. AW and W may complete in either order or the same cycle.
  - Once both are done, go to RESP.
- WR RESP:
  - in_bvalid[g] = out_bvalid; in_bresp[g] = out_bresp; out_bready = in_bready[g].
  - On out_bvalid & out_bready: last_wr = g, go to IDLE.
- RD IDLE: same selection rule using in_arvalid and last_rd.
- RD ADDR: out_ar* driven from master g; on the handshake, go to RESP.
- RD RESP:
  - R channel is routed to master g.
  - On out_rvalid & out_rready: last_rd = g, go to IDLE.
- Latency:
  - Grant is registered, so out_awvalid/out_arvalid rise one cycle after the in valid, in the cycle after arbitration.
  - At least one IDLE cycle separates back-to-back transactions on the same FSM.
- Non-granted masters see ready = 0 and bvalid/rvalid = 0 at all times.
- A single requester is re-granted repeatedly.
- A master holding valid high while not granted keeps waiting; valids are never dropped.

Test Plan:
- After reset, in_awvalid = 3'b001 with awaddr0 = 20'hA000: wr_grant = 0 one cycle later; out_awvalid = 1 with out_awaddr = 20'hA000; in_awready[1], in_awready[2] = 0.
- From reset, in_awvalid = 3'b111 held for three complete writes (wdata 16'h1111/16'h2222/16'h3333): slave observes the order 0, 1, 2; each B is routed only to its issuer.
- W before AW:
  - Master 1 asserts wvalid 2 cycles before awvalid: no grant until awvalid.
  - Then out_wvalid and out_awvalid both assert; in_bvalid[1] = 1 after the write.
  - Read-back of the address returns the written data.
- Concurrent channels:
  - Master 0 writes 16'hDEAD to 20'h0010 while master 2 reads 20'h0020 (preloaded 16'hBEEF).
  - Both FSMs are granted in the same cycle.
  - Master 2 gets rdata = 16'hBEEF; master 0 gets bresp = 2'b00.
- Response backpressure: in_bready[g] held 0 for 5 cycles in RESP: out_bready = 0 and grant stays; no new AW is forwarded to the slave until bready rises.
- Reset mid-transaction: axi_reset asserted in WR ADDR: next cycle FSM = IDLE; all outputs at reset values; last_wr = NUM_IN-1.

Source files
------------

// File: rtl/axi_rr_arbiter_if.sv
// AXI-Lite bundle with NUM_PORTS packed lanes; lane i owns slice i of every field.
// The arbiter uses one instance with NUM_IN lanes (masters side) and one with a single lane (slave side).
interface axi_rr_arbiter_if #(
  parameter int NUM_PORTS  = 1,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int STRB_WIDTH = (DATA_WIDTH + 7) / 8
);
  logic [NUM_PORTS*ADDR_WIDTH-1:0] awaddr;
  logic [NUM_PORTS-1:0]            awvalid;
  logic [NUM_PORTS-1:0]            awready;
  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata;
  logic [NUM_PORTS*STRB_WIDTH-1:0] wstrb;
  logic [NUM_PORTS-1:0]            wvalid;
  logic [NUM_PORTS-1:0]            wready;
  logic [NUM_PORTS*2-1:0]          bresp;
  logic [NUM_PORTS-1:0]            bvalid;
  logic [NUM_PORTS-1:0]            bready;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] araddr;
  logic [NUM_PORTS-1:0]            arvalid;
  logic [NUM_PORTS-1:0]            arready;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rdata;
  logic [NUM_PORTS*2-1:0]          rresp;
  logic [NUM_PORTS-1:0]            rvalid;
  logic [NUM_PORTS-1:0]            rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_rr_arbiter.sv
// N-to-1 AXI-Lite arbiter: independent round-robin write and read FSMs, each grant
// held from address through response so a write and a read from different masters can overlap.
module axi_rr_arbiter #(
  parameter int NUM_IN         = 3,
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int AXI_STRB_WIDTH = (AXI_DATA_WIDTH + 7) / 8
) (
  input  logic             axi_clk,
  input  logic             axi_reset,
  axi_rr_arbiter_if.slave  in_axi,
  axi_rr_arbiter_if.master out_axi
);

  localparam int GW = $clog2(NUM_IN);
  localparam logic [GW-1:0] LAST_INIT = GW'(NUM_IN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Nearest requester after 'last' wins; scanning farthest-first lets the nearest overwrite.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_IN-1:0] req,
                                             input logic [GW-1:0]     last);
    logic [GW-1:0] pick;
    int            idx;
    pick = last;
    for (int k = NUM_IN; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (req[idx]) pick = GW'(idx);
    end
    return pick;
  endfunction

  // Per-master views of the packed request fields
  logic [AXI_ADDR_WIDTH-1:0] awaddr_arr [NUM_IN];
  logic [AXI_DATA_WIDTH-1:0] wdata_arr  [NUM_IN];
  logic [AXI_STRB_WIDTH-1:0] wstrb_arr  [NUM_IN];
  logic [AXI_ADDR_WIDTH-1:0] araddr_arr [NUM_IN];

  // Write FSM state
  state_t         wr_state_reg, wr_state_next;
  logic [GW-1:0]  wr_grant_reg, wr_grant_next;
  logic [GW-1:0]  last_wr_reg, last_wr_next;
  logic           aw_done_reg, aw_done_next;
  logic           w_done_reg, w_done_next;

  // Read FSM state
  state_t         rd_state_reg, rd_state_next;
  logic [GW-1:0]  rd_grant_reg, rd_grant_next;
  logic [GW-1:0]  last_rd_reg, last_rd_next;

  // Write-side outputs
  logic [NUM_IN-1:0]         wr_sel;
  logic [NUM_IN-1:0]         wr_route;
  logic [AXI_ADDR_WIDTH-1:0] out_awaddr_c;
  logic                      out_awvalid_c;
  logic [AXI_DATA_WIDTH-1:0] out_wdata_c;
  logic [AXI_STRB_WIDTH-1:0] out_wstrb_c;
  logic                      out_wvalid_c;
  logic                      out_bready_c;
  logic [NUM_IN-1:0]         in_awready_c;
  logic [NUM_IN-1:0]         in_wready_c;
  logic [NUM_IN-1:0]         in_bvalid_c;

  // Read-side outputs
  logic [NUM_IN-1:0]         rd_sel;
  logic [NUM_IN-1:0]         rd_route;
  logic [AXI_ADDR_WIDTH-1:0] out_araddr_c;
  logic                      out_arvalid_c;
  logic                      out_rready_c;
  logic [NUM_IN-1:0]         in_arready_c;
  logic [NUM_IN-1:0]         in_rvalid_c;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_lane
      assign awaddr_arr[gi] = in_axi.awaddr[gi*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
      assign wdata_arr[gi]  = in_axi.wdata[gi*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
      assign wstrb_arr[gi]  = in_axi.wstrb[gi*AXI_STRB_WIDTH +: AXI_STRB_WIDTH];
      assign araddr_arr[gi] = in_axi.araddr[gi*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];

      assign in_axi.bresp[gi*2 +: 2] = wr_route[gi] ? out_axi.bresp : 2'b00;
      assign in_axi.rdata[gi*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] =
        rd_route[gi] ? out_axi.rdata : '0;
      assign in_axi.rresp[gi*2 +: 2] = rd_route[gi] ? out_axi.rresp : 2'b00;
    end
  endgenerate

  assign in_axi.awready  = in_awready_c;
  assign in_axi.wready   = in_wready_c;
  assign in_axi.bvalid   = in_bvalid_c;
  assign in_axi.arready  = in_arready_c;
  assign in_axi.rvalid   = in_rvalid_c;

  assign out_axi.awaddr  = out_awaddr_c;
  assign out_axi.awvalid = out_awvalid_c;
  assign out_axi.wdata   = out_wdata_c;
  assign out_axi.wstrb   = out_wstrb_c;
  assign out_axi.wvalid  = out_wvalid_c;
  assign out_axi.bready  = out_bready_c;
  assign out_axi.araddr  = out_araddr_c;
  assign out_axi.arvalid = out_arvalid_c;
  assign out_axi.rready  = out_rready_c;

  // ---------------- write FSM ----------------
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      wr_state_reg <= ST_IDLE;
      wr_grant_reg <= '0;
      last_wr_reg  <= LAST_INIT;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
    end else begin
      wr_state_reg <= wr_state_next;
      wr_grant_reg <= wr_grant_next;
      last_wr_reg  <= last_wr_next;
      aw_done_reg  <= aw_done_next;
      w_done_reg   <= w_done_next;
    end
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    wr_grant_next = wr_grant_reg;
    last_wr_next  = last_wr_reg;
    aw_done_next  = aw_done_reg;
    w_done_next   = w_done_reg;
    case (wr_state_reg)
      ST_IDLE: begin
        // W without AW never opens a grant
        if (|in_axi.awvalid) begin
          wr_grant_next = rr_pick(in_axi.awvalid, last_wr_reg);
          aw_done_next  = 1'b0;
          w_done_next   = 1'b0;
          wr_state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        aw_done_next = aw_done_reg || (out_awvalid_c && out_axi.awready[0]);
        w_done_next  = w_done_reg || (out_wvalid_c && out_axi.wready[0]);
        if (aw_done_next && w_done_next) wr_state_next = ST_RESP;
      end
      ST_RESP: begin
        if (out_axi.bvalid[0] && out_bready_c) begin
          last_wr_next  = wr_grant_reg;
          wr_state_next = ST_IDLE;
        end
      end
      default: wr_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_sel               = '0;
    wr_sel[wr_grant_reg] = 1'b1;
    wr_route             = '0;
    out_awaddr_c         = '0;
    out_awvalid_c        = 1'b0;
    out_wdata_c          = '0;
    out_wstrb_c          = '0;
    out_wvalid_c         = 1'b0;
    out_bready_c         = 1'b0;
    in_awready_c         = '0;
    in_wready_c          = '0;
    in_bvalid_c          = '0;
    case (wr_state_reg)
      ST_ADDR: begin
        out_awaddr_c  = awaddr_arr[wr_grant_reg];
        out_awvalid_c = in_axi.awvalid[wr_grant_reg] && !aw_done_reg;
        out_wdata_c   = wdata_arr[wr_grant_reg];
        out_wstrb_c   = wstrb_arr[wr_grant_reg];
        out_wvalid_c  = in_axi.wvalid[wr_grant_reg] && !w_done_reg;
        out_bready_c  = in_axi.bready[wr_grant_reg];
        in_awready_c  = wr_sel & {NUM_IN{out_axi.awready[0] && !aw_done_reg}};
        in_wready_c   = wr_sel & {NUM_IN{out_axi.wready[0] && !w_done_reg}};
      end
      ST_RESP: begin
        wr_route     = wr_sel;
        out_bready_c = in_axi.bready[wr_grant_reg];
        in_bvalid_c  = wr_sel & {NUM_IN{out_axi.bvalid[0]}};
      end
      default: ;
    endcase
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      rd_state_reg <= ST_IDLE;
      rd_grant_reg <= '0;
      last_rd_reg  <= LAST_INIT;
    end else begin
      rd_state_reg <= rd_state_next;
      rd_grant_reg <= rd_grant_next;
      last_rd_reg  <= last_rd_next;
    end
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    rd_grant_next = rd_grant_reg;
    last_rd_next  = last_rd_reg;
    case (rd_state_reg)
      ST_IDLE: begin
        if (|in_axi.arvalid) begin
          rd_grant_next = rr_pick(in_axi.arvalid, last_rd_reg);
          rd_state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (out_arvalid_c && out_axi.arready[0]) rd_state_next = ST_RESP;
      end
      ST_RESP: begin
        if (out_axi.rvalid[0] && out_rready_c) begin
          last_rd_next  = rd_grant_reg;
          rd_state_next = ST_IDLE;
        end
      end
      default: rd_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_sel               = '0;
    rd_sel[rd_grant_reg] = 1'b1;
    rd_route             = '0;
    out_araddr_c         = '0;
    out_arvalid_c        = 1'b0;
    out_rready_c         = 1'b0;
    in_arready_c         = '0;
    in_rvalid_c          = '0;
    case (rd_state_reg)
      ST_ADDR: begin
        out_araddr_c  = araddr_arr[rd_grant_reg];
        out_arvalid_c = in_axi.arvalid[rd_grant_reg];
        in_arready_c  = rd_sel & {NUM_IN{out_axi.arready[0]}};
      end
      ST_RESP: begin
        rd_route     = rd_sel;
        out_rready_c = in_axi.rready[rd_grant_reg];
        in_rvalid_c  = rd_sel & {NUM_IN{out_axi.rvalid[0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed bench for axi_rr_arbiter: three masters driven from one initial block,
// a small memory-backed AXI-Lite slave behind the arbiter.
module tb_axi_rr_arbiter;
  localparam int N  = 3;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int SW = (DW + 7) / 8;

  logic axi_clk = 1'b0;
  logic axi_reset;
  always #5 axi_clk = ~axi_clk;

  axi_rr_arbiter_if #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) in_axi ();
  axi_rr_arbiter_if #(.NUM_PORTS(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) out_axi ();

  axi_rr_arbiter #(
    .NUM_IN(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_STRB_WIDTH(SW)
  ) dut (
    .axi_clk   (axi_clk),
    .axi_reset (axi_reset),
    .in_axi    (in_axi),
    .out_axi   (out_axi)
  );

  // ---------------- slave model ----------------
  logic          aw_have, w_have, b_q, r_q;
  logic [AW-1:0] aw_addr_q;
  logic [DW-1:0] w_data_q, r_data_q;
  logic [SW-1:0] w_strb_q;
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] wr_log [$];

  assign out_axi.awready = !aw_have;
  assign out_axi.wready  = !w_have;
  assign out_axi.bvalid  = b_q;
  assign out_axi.bresp   = 2'b00;
  assign out_axi.arready = !r_q;
  assign out_axi.rvalid  = r_q;
  assign out_axi.rdata   = r_data_q;
  assign out_axi.rresp   = 2'b00;

  always @(posedge axi_clk) begin
    if (axi_reset) begin
      aw_have     <= 1'b0;
      w_have      <= 1'b0;
      b_q         <= 1'b0;
      r_q         <= 1'b0;
      r_data_q    <= '0;
      mem[8'h20]  <= 16'hBEEF;
    end else begin
      if (out_axi.awvalid[0] && !aw_have) begin
        aw_have   <= 1'b1;
        aw_addr_q <= out_axi.awaddr;
      end
      if (out_axi.wvalid[0] && !w_have) begin
        w_have   <= 1'b1;
        w_data_q <= out_axi.wdata;
        w_strb_q <= out_axi.wstrb;
      end
      if (aw_have && w_have && !b_q) begin
        for (int b = 0; b < SW; b++)
          if (w_strb_q[b]) mem[aw_addr_q[7:0]][b*8 +: 8] <= w_data_q[b*8 +: 8];
        wr_log.push_back(w_data_q);
        b_q <= 1'b1;
      end
      if (b_q && out_axi.bready[0]) begin
        b_q     <= 1'b0;
        aw_have <= 1'b0;
        w_have  <= 1'b0;
      end
      if (out_axi.arvalid[0] && !r_q) begin
        r_q      <= 1'b1;
        r_data_q <= mem[out_axi.araddr[7:0]];
      end else if (r_q && out_axi.rready[0]) begin
        r_q <= 1'b0;
      end
    end
  end

  // ---------------- bookkeeping ----------------
  int            n_cmp = 0;
  int            n_bad = 0;
  int            b_cnt [N];
  int            r_cnt [N];
  logic [1:0]    b_last [N];
  logic [DW-1:0] r_last [N];
  int            route_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, retire accepted valids just after the edge.
  task automatic cycle();
    logic [N-1:0] aw_hs, w_hs, ar_hs, b_hs, r_hs;
    @(negedge axi_clk);
    aw_hs = in_axi.awvalid & in_axi.awready;
    w_hs  = in_axi.wvalid & in_axi.wready;
    ar_hs = in_axi.arvalid & in_axi.arready;
    b_hs  = in_axi.bvalid & in_axi.bready;
    r_hs  = in_axi.rvalid & in_axi.rready;
    if ($countones(in_axi.bvalid) > 1 || $countones(in_axi.rvalid) > 1) route_err++;
    for (int i = 0; i < N; i++) begin
      if (b_hs[i]) begin
        b_cnt[i]++;
        b_last[i] = in_axi.bresp[i*2 +: 2];
        $display("B  master %0d bresp %0h", i, b_last[i]);
      end
      if (r_hs[i]) begin
        r_cnt[i]++;
        r_last[i] = in_axi.rdata[i*DW +: DW];
        $display("R  master %0d rdata %04h", i, r_last[i]);
      end
    end
    @(posedge axi_clk);
    #1;
    in_axi.awvalid = in_axi.awvalid & ~aw_hs;
    in_axi.wvalid  = in_axi.wvalid & ~w_hs;
    in_axi.arvalid = in_axi.arvalid & ~ar_hs;
  endtask

  task automatic do_reset();
    axi_reset      = 1'b1;
    in_axi.awvalid = '0;
    in_axi.wvalid  = '0;
    in_axi.arvalid = '0;
    in_axi.bready  = '1;
    in_axi.rready  = '1;
    for (int i = 0; i < N; i++) begin
      b_cnt[i]  = 0;
      r_cnt[i]  = 0;
      b_last[i] = 2'b11;
      r_last[i] = '0;
    end
    cycle();
    cycle();
    axi_reset = 1'b0;
  endtask

  task automatic set_write(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    in_axi.awaddr[m*AW +: AW] = addr;
    in_axi.wdata[m*DW +: DW]  = data;
    in_axi.wstrb[m*SW +: SW]  = '1;
    in_axi.awvalid[m]         = 1'b1;
    in_axi.wvalid[m]          = 1'b1;
  endtask

  task automatic set_read(input int m, input logic [AW-1:0] addr);
    in_axi.araddr[m*AW +: AW] = addr;
    in_axi.arvalid[m]         = 1'b1;
  endtask

  task automatic wait_b(input int m, input int target, input string tag);
    for (int k = 0; k < 40 && b_cnt[m] < target; k++) cycle();
    check_val(tag, b_cnt[m], target);
  endtask

  task automatic wait_r(input int m, input int target, input string tag);
    for (int k = 0; k < 40 && r_cnt[m] < target; k++) cycle();
    check_val(tag, r_cnt[m], target);
  endtask

  int bp_bready, bp_grant, bp_aw, base;

  initial begin
    in_axi.awaddr = '0;
    in_axi.wdata  = '0;
    in_axi.wstrb  = '0;
    in_axi.araddr = '0;
    do_reset();

    // reset state
    check_val("rst_out_awvalid", out_axi.awvalid, 0);
    check_val("rst_out_arvalid", out_axi.arvalid, 0);
    check_val("rst_in_awready", in_axi.awready, 0);
    check_val("rst_last_wr", dut.last_wr_reg, 2);
    check_val("rst_last_rd", dut.last_rd_reg, 2);

    // single AW request: registered grant, forwarded one cycle later
    in_axi.awaddr[0*AW +: AW] = 20'hA000;
    in_axi.awvalid = 3'b001;
    #1;
    check_val("t1_awvalid_same_cycle", out_axi.awvalid, 0);
    cycle();
    check_val("t1_wr_grant", dut.wr_grant_reg, 0);
    check_val("t1_out_awvalid", out_axi.awvalid, 1);
    check_val("t1_out_awaddr", out_axi.awaddr, 32'hA000);
    check_val("t1_awready_others", in_axi.awready[2:1], 0);
    in_axi.wdata[0*DW +: DW] = 16'h0A0A;
    in_axi.wstrb[0*SW +: SW] = '1;
    in_axi.wvalid[0] = 1'b1;
    wait_b(0, 1, "t1_b0");

    // three simultaneous writers: round-robin order 0,1,2
    do_reset();
    base = wr_log.size();
    set_write(0, 20'h00101, 16'h1111);
    set_write(1, 20'h00102, 16'h2222);
    set_write(2, 20'h00103, 16'h3333);
    wait_b(0, 1, "t2_b0");
    wait_b(1, 1, "t2_b1");
    wait_b(2, 1, "t2_b2");
    check_val("t2_log_size", wr_log.size() - base, 3);
    check_val("t2_order0", wr_log[base], 16'h1111);
    check_val("t2_order1", wr_log[base+1], 16'h2222);
    check_val("t2_order2", wr_log[base+2], 16'h3333);

    // W ahead of AW on master 1
    in_axi.wdata[1*DW +: DW] = 16'h5A5A;
    in_axi.wstrb[1*SW +: SW] = '1;
    in_axi.awaddr[1*AW +: AW] = 20'h00040;
    in_axi.wvalid[1] = 1'b1;
    cycle();
    check_val("t3_idle_w_only_a", dut.wr_state_reg, 0);
    cycle();
    check_val("t3_idle_w_only_b", dut.wr_state_reg, 0);
    check_val("t3_out_wvalid_idle", out_axi.wvalid, 0);
    in_axi.awvalid[1] = 1'b1;
    cycle();
    check_val("t3_wr_grant", dut.wr_grant_reg, 1);
    check_val("t3_out_awvalid", out_axi.awvalid, 1);
    check_val("t3_out_wvalid", out_axi.wvalid, 1);
    wait_b(1, 2, "t3_b1");
    set_read(1, 20'h00040);
    wait_r(1, 1, "t3_r1");
    check_val("t3_readback", r_last[1], 16'h5A5A);

    // concurrent write (master 0) and read (master 2)
    set_write(0, 20'h00010, 16'hDEAD);
    set_read(2, 20'h00020);
    cycle();
    check_val("t4_wr_state", dut.wr_state_reg, 1);
    check_val("t4_rd_state", dut.rd_state_reg, 1);
    check_val("t4_wr_grant", dut.wr_grant_reg, 0);
    check_val("t4_rd_grant", dut.rd_grant_reg, 2);
    wait_b(0, 2, "t4_b0");
    wait_r(2, 1, "t4_r2");
    check_val("t4_rdata2", r_last[2], 16'hBEEF);
    check_val("t4_bresp0", b_last[0], 2'b00);

    // B backpressure from master 1 while master 2 waits with AW
    in_axi.bready[1] = 1'b0;
    set_write(1, 20'h00050, 16'h7777);
    set_write(2, 20'h00060, 16'h6666);
    for (int k = 0; k < 20 && dut.wr_state_reg != 2'd2; k++) cycle();
    check_val("t5_reach_resp", dut.wr_state_reg, 2);
    bp_bready = 0;
    bp_grant  = 0;
    bp_aw     = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (out_axi.bready !== 1'b0) bp_bready++;
      if (dut.wr_grant_reg !== 2'd1) bp_grant++;
      if (out_axi.awvalid !== 1'b0) bp_aw++;
    end
    check_val("t5_out_bready_low", bp_bready, 0);
    check_val("t5_grant_held", bp_grant, 0);
    check_val("t5_no_new_aw", bp_aw, 0);
    check_val("t5_no_b_yet", b_cnt[1], 2);
    in_axi.bready[1] = 1'b1;
    wait_b(1, 3, "t5_b1");
    wait_b(2, 2, "t5_b2");
    check_val("t5_order_a", wr_log[wr_log.size()-2], 16'h7777);
    check_val("t5_order_b", wr_log[wr_log.size()-1], 16'h6666);

    // move last_wr away from its reset value, then reset during ADDR
    set_write(0, 20'h00070, 16'h1357);
    wait_b(0, 3, "t6_b0");
    check_val("t6_last_wr_pre", dut.last_wr_reg, 0);
    in_axi.awaddr[1*AW +: AW] = 20'h00080;
    in_axi.awvalid[1] = 1'b1;
    cycle();
    check_val("t6_in_addr", dut.wr_state_reg, 1);
    axi_reset = 1'b1;
    cycle();
    check_val("t6_rst_state", dut.wr_state_reg, 0);
    check_val("t6_rst_last_wr", dut.last_wr_reg, 2);
    check_val("t6_rst_awvalid", out_axi.awvalid, 0);
    check_val("t6_rst_awaddr", out_axi.awaddr, 0);
    check_val("t6_rst_awready", in_axi.awready, 0);
    in_axi.awvalid = '0;
    cycle();
    axi_reset = 1'b0;

    check_val("single_route", route_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
